// File: rtl/neuron_array_core.sv
// -----------------------------------------------------------------------------
// neuron_array_core
//   Time-multiplexed bank of integrate-and-fire neurons. Potentials are held
//   in an internal register file. Input spike events (valid/ready) add a
//   selected weight to one neuron with saturation. done_pic_i starts a sweep
//   that leaks every neuron, compares against the thresholds, and streams the
//   indices of fired neurons out over a valid/ready handshake.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   evt_valid_i/ready_o    input event handshake (ready only while accumulating)
//   evt_idx_i, evt_wsel_i  target neuron, weight type
//   weights_i              packed weights, type t at [t*WEIGHT_W +: WEIGHT_W]
//   pos/neg_threshold_i    fire / floor-reset thresholds (signed)
//   leak_value_i           signed leak applied during the sweep
//   pos/neg_reset_i        potential loaded after fire / floor-reset
//   done_pic_i             end-of-picture pulse, starts the sweep
//   spike_valid_o/ready_i  fired-neuron handshake, index on spike_idx_o
//   pic_done_o             one-cycle pulse once the sweep and all spikes finish
//   busy_o                 sweep or drain in progress
//   err_o                  sticky: out-of-range event index or weight select
//   rd_idx_i, rd_pot_o     combinational debug readback of one potential
// -----------------------------------------------------------------------------
module neuron_array_core #(
    parameter int NUM_NEURONS  = 16,
    parameter int POT_W        = 8,
    parameter int WEIGHT_W     = 8,
    parameter int NUM_WTYPES   = 4,
    parameter bit LEAK_PERSIST = 1'b0,
    localparam int IDX_W       = $clog2(NUM_NEURONS),
    localparam int SEL_W       = $clog2(NUM_WTYPES)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           evt_valid_i,
    output logic                           evt_ready_o,
    input  logic [IDX_W-1:0]               evt_idx_i,
    input  logic [SEL_W-1:0]               evt_wsel_i,
    input  logic [NUM_WTYPES*WEIGHT_W-1:0] weights_i,
    input  logic [POT_W-1:0]               pos_threshold_i,
    input  logic [POT_W-1:0]               neg_threshold_i,
    input  logic [POT_W-1:0]               leak_value_i,
    input  logic [POT_W-1:0]               pos_reset_i,
    input  logic [POT_W-1:0]               neg_reset_i,
    input  logic                           done_pic_i,
    output logic                           spike_valid_o,
    input  logic                           spike_ready_i,
    output logic [IDX_W-1:0]               spike_idx_o,
    output logic                           pic_done_o,
    output logic                           busy_o,
    output logic                           err_o,
    input  logic [IDX_W-1:0]               rd_idx_i,
    output logic [POT_W-1:0]               rd_pot_o
);

    typedef enum logic [1:0] {
        S_ACC,
        S_FIRE,
        S_DONE
    } state_e;

    // One extra bit so NUM_NEURONS / NUM_WTYPES themselves are representable.
    localparam logic [IDX_W:0] NUM_N_C = (IDX_W + 1)'(NUM_NEURONS);
    localparam logic [SEL_W:0] NUM_T_C = (SEL_W + 1)'(NUM_WTYPES);
    localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(NUM_NEURONS - 1);

    state_e                  state_q;
    logic signed [POT_W-1:0] pot_q [NUM_NEURONS];
    logic [IDX_W-1:0]        cnt_q;
    logic                    spike_valid_q;
    logic [IDX_W-1:0]        spike_idx_q;
    logic                    pic_done_q;
    logic                    err_q;

    // Sums are formed one bit wider; overflow shows up as the two top bits
    // disagreeing, and the sign of the wide sum picks the rail.
    function automatic logic signed [POT_W-1:0] sat(input logic signed [POT_W:0] v);
        if (v[POT_W] != v[POT_W-1]) begin
            return v[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
        end
        return v[POT_W-1:0];
    endfunction

    // ---------------------------------------------------------------- events
    logic                    evt_idx_ok;
    logic                    evt_ok;
    logic [WEIGHT_W-1:0]     weight_sel;
    logic signed [POT_W-1:0] acc_cur;
    logic signed [POT_W:0]   acc_sum_d;

    assign evt_idx_ok = ({1'b0, evt_idx_i} < NUM_N_C);
    assign evt_ok     = evt_idx_ok && ({1'b0, evt_wsel_i} < NUM_T_C);

    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        weight_sel = '0;
        for (int t = 0; t < NUM_WTYPES; t++) begin
            if (evt_wsel_i == SEL_W'(t)) begin
                weight_sel = weights_i[t*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    assign acc_cur   = evt_idx_ok ? pot_q[evt_idx_i] : '0;
    assign acc_sum_d = {acc_cur[POT_W-1], acc_cur}
                     + {{(POT_W + 1 - WEIGHT_W){weight_sel[WEIGHT_W-1]}}, weight_sel};

    // ----------------------------------------------------------------- sweep
    logic signed [POT_W-1:0] sw_cur;
    logic signed [POT_W:0]   sw_sum_d;
    logic signed [POT_W-1:0] sw_calc_d;
    logic                    sw_fire;
    logic                    sw_floor;
    logic                    sw_last;
    logic                    stall;

    assign sw_cur    = pot_q[cnt_q];
    assign sw_sum_d  = {sw_cur[POT_W-1], sw_cur} + {leak_value_i[POT_W-1], leak_value_i};
    assign sw_calc_d = sat(sw_sum_d);
    assign sw_fire   = (sw_calc_d >= $signed(pos_threshold_i));
    assign sw_floor  = (sw_calc_d <  $signed(neg_threshold_i));
    assign sw_last   = (cnt_q == LAST_IDX_C);
    // A spike still waiting downstream blocks the next evaluation, so the
    // output register is never overwritten before it is accepted.
    assign stall     = spike_valid_q && !spike_ready_i;

    // ------------------------------------------------------------ state/regs
    // NOTE: all state updates use non-blocking assignments so every read in
    // this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the potential file is cleared on reset because a reset
            // must abort any picture and start from zero potentials.
            for (int n = 0; n < NUM_NEURONS; n++) begin
                pot_q[n] <= '0;
            end
            state_q       <= S_ACC;
            cnt_q         <= '0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            pic_done_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            pic_done_q <= 1'b0;
            // Drain an accepted spike; a fire below can reload in the same
            // cycle, giving back-to-back spikes without a bubble.
            if (spike_valid_q && spike_ready_i) begin
                spike_valid_q <= 1'b0;
            end

            case (state_q)
                S_ACC: begin
                    if (evt_valid_i) begin
                        if (evt_ok) begin
                            pot_q[evt_idx_i] <= sat(acc_sum_d);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    if (done_pic_i) begin
                        state_q <= S_FIRE;
                        cnt_q   <= '0;
                    end
                end

                S_FIRE: begin
                    if (!stall) begin
                        if (sw_fire) begin
                            pot_q[cnt_q]  <= pos_reset_i;
                            spike_valid_q <= 1'b1;
                            spike_idx_q   <= cnt_q;
                        end else if (sw_floor) begin
                            pot_q[cnt_q] <= neg_reset_i;
                        end else if (LEAK_PERSIST) begin
                            pot_q[cnt_q] <= sw_calc_d;
                        end
                        if (sw_last) begin
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + IDX_W'(1);
                        end
                    end
                end

                S_DONE: begin
                    // Finish in the cycle the last spike is taken (or at once
                    // if none is pending).
                    if (!spike_valid_q || spike_ready_i) begin
                        pic_done_q <= 1'b1;
                        state_q    <= S_ACC;
                    end
                end

                default: state_q <= S_ACC;
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    assign evt_ready_o   = (state_q == S_ACC);
    assign busy_o        = (state_q != S_ACC);
    assign spike_valid_o = spike_valid_q;
    assign spike_idx_o   = spike_idx_q;
    assign pic_done_o    = pic_done_q;
    assign err_o         = err_q;
    assign rd_pot_o      = ({1'b0, rd_idx_i} < NUM_N_C) ? pot_q[rd_idx_i] : '0;

endmodule

// File: tb/tb_neuron_array_core.sv
// -----------------------------------------------------------------------------
// tb_neuron_array_core
//   Self-checking bench. dut is the default configuration; dut_p shares the
//   stimulus but is built with LEAK_PERSIST=1, 12 neurons and 3 weight types
//   so the stored-leak option and the error flag can be exercised.
//   Expected spike indices are queued when stimulus is applied and popped
//   when the DUT hands a spike over.
// -----------------------------------------------------------------------------
module tb_neuron_array_core;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        evt_valid_i = 1'b0;
    logic [3:0]  evt_idx_i = '0;
    logic [1:0]  evt_wsel_i = '0;
    logic [31:0] weights_i = '0;
    logic [7:0]  pos_threshold_i = '0;
    logic [7:0]  neg_threshold_i = '0;
    logic [7:0]  leak_value_i = '0;
    logic [7:0]  pos_reset_i = '0;
    logic [7:0]  neg_reset_i = '0;
    logic        done_pic_i = 1'b0;
    logic        spike_ready_i = 1'b1;
    logic [3:0]  rd_idx_i = '0;

    logic              evt_ready_o, spike_valid_o, pic_done_o, busy_o, err_o;
    logic [3:0]        spike_idx_o;
    logic signed [7:0] rd_pot_o;

    logic              evt_ready_p, spike_valid_p, pic_done_p, busy_p, err_p;
    logic [3:0]        spike_idx_p;
    logic signed [7:0] rd_pot_p;

    neuron_array_core dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .evt_valid_i(evt_valid_i), .evt_ready_o(evt_ready_o),
        .evt_idx_i(evt_idx_i), .evt_wsel_i(evt_wsel_i), .weights_i(weights_i),
        .pos_threshold_i(pos_threshold_i), .neg_threshold_i(neg_threshold_i),
        .leak_value_i(leak_value_i), .pos_reset_i(pos_reset_i), .neg_reset_i(neg_reset_i),
        .done_pic_i(done_pic_i), .spike_valid_o(spike_valid_o), .spike_ready_i(spike_ready_i),
        .spike_idx_o(spike_idx_o), .pic_done_o(pic_done_o), .busy_o(busy_o), .err_o(err_o),
        .rd_idx_i(rd_idx_i), .rd_pot_o(rd_pot_o)
    );

    neuron_array_core #(
        .NUM_NEURONS(12), .NUM_WTYPES(3), .LEAK_PERSIST(1'b1)
    ) dut_p (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .evt_valid_i(evt_valid_i), .evt_ready_o(evt_ready_p),
        .evt_idx_i(evt_idx_i), .evt_wsel_i(evt_wsel_i), .weights_i(weights_i[23:0]),
        .pos_threshold_i(pos_threshold_i), .neg_threshold_i(neg_threshold_i),
        .leak_value_i(leak_value_i), .pos_reset_i(pos_reset_i), .neg_reset_i(neg_reset_i),
        .done_pic_i(done_pic_i), .spike_valid_o(spike_valid_p), .spike_ready_i(spike_ready_i),
        .spike_idx_o(spike_idx_p), .pic_done_o(pic_done_p), .busy_o(busy_p), .err_o(err_p),
        .rd_idx_i(rd_idx_i), .rd_pot_o(rd_pot_p)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int n_spikes = 0;
    int exp_q[$];
    int exp_idx;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        evt_valid_i = 1'b0;
        done_pic_i  = 1'b0;
        rst_ni      = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic set_w(input int t, input int v);
        weights_i[t*8 +: 8] = 8'(v);
    endtask

    task automatic send_evt(input int idx, input int wsel);
        evt_valid_i = 1'b1;
        evt_idx_i   = 4'(idx);
        evt_wsel_i  = 2'(wsel);
        tick();
        evt_valid_i = 1'b0;
    endtask

    task automatic read_pot(input int idx);
        rd_idx_i = 4'(idx);
        #1;
    endtask

    // Pulse done_pic_i and count edges until pic_done_o, bounded.
    task automatic do_sweep(output int lat);
        done_pic_i = 1'b1;
        tick();
        done_pic_i = 1'b0;
        lat = 0;
        while (!pic_done_o && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    // Scoreboard: a spike is handed over when valid&ready at the next edge.
    always @(negedge clk_i) begin
        if (rst_ni && spike_valid_o && spike_ready_i) begin
            n_spikes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spike_unexpected: got idx %0d, expected none", spike_idx_o);
            end else begin
                exp_idx = exp_q.pop_front();
                check("spike_idx", int'(spike_idx_o), exp_idx);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int idx;
        int wsel;
        int exp_pot;
    } acc_vec_t;

    acc_vec_t vecs[9];
    int lat;
    int base_spikes;
    int bad;

    initial begin
        // Accumulation vectors with weights w0=+10, w1=+50, w2=-60, w3=+20.
        vecs[0] = '{2, 1, 50};
        vecs[1] = '{2, 1, 100};
        vecs[2] = '{2, 1, 127};
        vecs[3] = '{3, 2, -60};
        vecs[4] = '{3, 2, -120};
        vecs[5] = '{3, 2, -128};
        vecs[6] = '{3, 0, -118};
        vecs[7] = '{4, 3, 20};
        vecs[8] = '{4, 0, 30};

        pos_threshold_i = 8'(100);
        neg_threshold_i = 8'(-100);
        do_reset();

        // Reset state
        check("rst_spike_valid", int'(spike_valid_o), 0);
        check("rst_spike_idx", int'(spike_idx_o), 0);
        check("rst_pic_done", int'(pic_done_o), 0);
        check("rst_err", int'(err_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_evt_ready", int'(evt_ready_o), 1);
        read_pot(2);
        check("rst_pot2", int'(rd_pot_o), 0);

        // Accumulation with saturation at both rails
        set_w(0, 10); set_w(1, 50); set_w(2, -60); set_w(3, 20);
        for (int i = 0; i < 9; i++) begin
            send_evt(vecs[i].idx, vecs[i].wsel);
            read_pot(vecs[i].idx);
            check("acc_pot", int'(rd_pot_o), vecs[i].exp_pot);
        end
        check("acc_err", int'(err_o), 0);

        // Floor reset after leak, no spike
        do_reset();
        set_w(0, -100); set_w(2, -60);
        send_evt(5, 0);
        send_evt(5, 2);
        read_pot(5);
        check("floor_pre_pot5", int'(rd_pot_o), -128);
        leak_value_i    = 8'(-5);
        neg_threshold_i = 8'(-120);
        neg_reset_i     = 8'(0);
        pos_threshold_i = 8'(100);
        base_spikes = n_spikes;
        do_sweep(lat);
        check("floor_lat", lat, 17);
        check("floor_spikes", n_spikes - base_spikes, 0);
        read_pot(5);
        check("floor_pot5", int'(rd_pot_o), 0);
        read_pot(6);
        check("floor_pot6_keep", int'(rd_pot_o), 0);

        // Firing with free-flowing ready, including back-to-back spikes
        do_reset();
        leak_value_i    = 8'(0);
        neg_threshold_i = 8'(-100);
        pos_threshold_i = 8'(20);
        pos_reset_i     = 8'(5);
        spike_ready_i   = 1'b1;
        set_w(0, 25); set_w(1, 30); set_w(2, 19); set_w(3, 20);
        send_evt(0, 0);
        send_evt(1, 0);
        send_evt(7, 2);
        send_evt(9, 3);
        send_evt(15, 1);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(9); exp_q.push_back(15);
        do_sweep(lat);
        check("fire_lat", lat, 17);
        check("fire_drained", exp_q.size(), 0);
        read_pot(0);
        check("fire_pot0", int'(rd_pot_o), 5);
        read_pot(7);
        check("fire_pot7_below", int'(rd_pot_o), 19);
        read_pot(15);
        check("fire_pot15", int'(rd_pot_o), 5);

        // Backpressure: first spike held for 10 cycles, sweep frozen
        do_reset();
        send_evt(0, 0);
        send_evt(15, 1);
        exp_q.push_back(0); exp_q.push_back(15);
        spike_ready_i = 1'b0;
        done_pic_i = 1'b1;
        tick();
        done_pic_i = 1'b0;
        tick();
        check("stall_first_valid", int'(spike_valid_o), 1);
        check("stall_first_idx", int'(spike_idx_o), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", int'(spike_valid_o), 1);
            check("stall_idx", int'(spike_idx_o), 0);
            check("stall_no_done", int'(pic_done_o), 0);
        end
        read_pot(15);
        check("stall_pot15_frozen", int'(rd_pot_o), 30);
        spike_ready_i = 1'b1;
        lat = 11;
        while (!pic_done_o && lat < 200) begin
            tick();
            lat++;
        end
        check("stall_lat", lat, 27);
        check("stall_drained", exp_q.size(), 0);

        // Leak persistence: dut keeps pre-leak value, dut_p stores it
        do_reset();
        pos_threshold_i = 8'(100);
        neg_threshold_i = 8'(-100);
        leak_value_i    = 8'(-3);
        set_w(0, 10);
        send_evt(6, 0);
        do_sweep(lat);
        read_pot(6);
        check("leak_keep_pot6", int'(rd_pot_o), 10);
        check("leak_persist_pot6", int'(rd_pot_p), 7);
        read_pot(0);
        check("leak_keep_pot0", int'(rd_pot_o), 0);
        check("leak_persist_pot0", int'(rd_pot_p), -3);

        // Error flag: index 13 is out of range only for the 12-neuron bank
        check("err_p_clean", int'(err_p), 0);
        send_evt(13, 0);
        check("err_p_idx", int'(err_p), 1);
        check("err_main_clean", int'(err_o), 0);
        read_pot(13);
        check("err_main_pot13", int'(rd_pot_o), 10);
        do_reset();
        set_w(3, 7);
        send_evt(1, 3);
        check("err_p_wsel", int'(err_p), 1);
        read_pot(1);
        check("err_main_pot1", int'(rd_pot_o), 7);
        check("err_p_pot1", int'(rd_pot_p), 0);
        send_evt(2, 0);
        check("err_p_sticky", int'(err_p), 1);

        // Event accepted together with done_pic_i is seen by the sweep
        do_reset();
        leak_value_i    = 8'(0);
        pos_threshold_i = 8'(20);
        pos_reset_i     = 8'(0);
        set_w(3, 20);
        exp_q.push_back(0);
        evt_valid_i = 1'b1;
        evt_idx_i   = 4'd0;
        evt_wsel_i  = 2'd3;
        done_pic_i  = 1'b1;
        tick();
        evt_valid_i = 1'b0;
        done_pic_i  = 1'b0;
        lat = 0;
        while (!pic_done_o && lat < 200) begin
            tick();
            lat++;
        end
        check("same_cycle_lat", lat, 17);
        check("same_cycle_drained", exp_q.size(), 0);

        // Reset in the middle of a sweep aborts it
        set_w(0, 25);
        send_evt(3, 0);
        send_evt(8, 0);
        done_pic_i = 1'b1;
        tick();
        done_pic_i = 1'b0;
        tick();
        tick();
        check("midrst_busy_before", int'(busy_o), 1);
        rst_ni = 1'b0;
        #1;
        check("midrst_spike_valid", int'(spike_valid_o), 0);
        check("midrst_busy", int'(busy_o), 0);
        read_pot(3);
        check("midrst_pot3", int'(rd_pot_o), 0);
        read_pot(8);
        check("midrst_pot8", int'(rd_pot_o), 0);
        tick();
        rst_ni = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (spike_valid_o || busy_o) bad++;
        end
        check("midrst_quiet", bad, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
